// File: rtl/wave_capture_pkg.sv
// Shared types and constants for the wave capture path: FSM states, buffer depth
// and the conversion from a signed sample's top byte to offset-binary.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        CAP_ARMED  = 2'd0,
        CAP_ACTIVE = 2'd1,
        CAP_WAIT   = 2'd2
    } cap_state_t;

    localparam int unsigned CAP_DEPTH     = 256;
    localparam logic [7:0]  CAP_SIGN_FLIP = 8'h80;

    // Inverting the sign bit maps two's complement onto offset-binary.
    function automatic logic [7:0] to_offset_binary(input logic [7:0] i_top_byte);
        return i_top_byte ^ CAP_SIGN_FLIP;
    endfunction

endpackage

// File: rtl/wave_capture_if.sv
// Sample-stream input, display handshake and RAM write port of the capture block.
interface wave_capture_if #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 9
);
    logic                new_sample_ready;
    logic [SAMPLE_W-1:0] new_sample_in;
    logic                wave_display_idle;
    logic [ADDR_W-1:0]   write_address;
    logic                write_enable;
    logic [7:0]          write_sample;
    logic                read_index;

    modport master (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_enable, write_sample, read_index
    );

    modport slave (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index
    );
endinterface

// File: rtl/wave_capture_zero_cross.sv
// Trigger source: remembers the sign of the last strobed sample and counts strobes
// while armed; fires on a negative-to-non-negative crossing or on timeout.
module zero_cross_detect #(
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_strobe,
    input  logic i_msb,
    input  logic i_armed,
    output logic o_trigger
);
    localparam int TO_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

    logic            r_prev_neg;
    logic [TO_W-1:0] r_timeout;
    logic            w_timeout_hit;

    assign w_timeout_hit = (ARM_TIMEOUT != 0) && (r_timeout == TO_W'(ARM_TIMEOUT - 1));
    assign o_trigger     = i_armed && i_strobe && ((r_prev_neg && !i_msb) || w_timeout_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_neg <= 1'b0;
            r_timeout  <= '0;
        end else begin
            if (i_strobe)
                r_prev_neg <= i_msb;
            if (o_trigger || !i_armed)
                r_timeout <= '0;
            else if (i_strobe)
                r_timeout <= r_timeout + 1'b1;
        end
    end
endmodule

// File: rtl/wave_capture.sv
// Captures one trigger-aligned buffer of samples into the hidden RAM half, then
// swaps halves during display idle and re-arms.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    wave_capture_if.master cap
);
    localparam int ADDR_W = DEPTH_LOG2 + 1;

    cap_state_t            r_state, w_state;
    logic [DEPTH_LOG2-1:0] r_count, w_count, w_wr_count;
    logic                  r_read_index, w_read_index;
    logic                  r_we, w_we;
    logic [ADDR_W-1:0]     r_addr, w_addr;
    logic [7:0]            r_sample, w_sample;
    logic                  w_accept;
    logic                  w_trigger;
    logic                  w_unused_low_bits;

    assign w_unused_low_bits = ^cap.new_sample_in[SAMPLE_W-9:0];

    zero_cross_detect #(
        .ARM_TIMEOUT(ARM_TIMEOUT)
    ) u_zcd (
        .clk      (clk),
        .reset    (reset),
        .i_strobe (cap.new_sample_ready),
        .i_msb    (cap.new_sample_in[SAMPLE_W-1]),
        .i_armed  (r_state == CAP_ARMED),
        .o_trigger(w_trigger)
    );

    always_comb begin
        w_state      = r_state;
        w_count      = r_count;
        w_read_index = r_read_index;
        w_accept     = 1'b0;
        w_wr_count   = r_count;
        w_we         = 1'b0;
        w_addr       = r_addr;
        w_sample     = r_sample;
        case (r_state)
            CAP_ARMED: begin
                if (w_trigger) begin
                    w_accept   = 1'b1;
                    w_wr_count = '0;
                    w_count    = DEPTH_LOG2'(1);
                    w_state    = CAP_ACTIVE;
                end
            end
            CAP_ACTIVE: begin
                if (cap.new_sample_ready) begin
                    w_accept = 1'b1;
                    w_count  = r_count + 1'b1;
                    if (r_count == '1)
                        w_state = CAP_WAIT;
                end
            end
            CAP_WAIT: begin
                // Strobes here only feed the sign history inside the detector.
                if (cap.wave_display_idle) begin
                    w_read_index = ~r_read_index;
                    w_state      = CAP_ARMED;
                end
            end
            default: w_state = CAP_ARMED;
        endcase
        if (w_accept) begin
            w_we     = 1'b1;
            w_addr   = {~r_read_index, w_wr_count};
            w_sample = to_offset_binary(cap.new_sample_in[SAMPLE_W-1 -: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= CAP_ARMED;
            r_count      <= '0;
            r_read_index <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_sample     <= '0;
        end else begin
            r_state      <= w_state;
            r_count      <= w_count;
            r_read_index <= w_read_index;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_sample     <= w_sample;
        end
    end

    assign cap.write_enable  = r_we;
    assign cap.write_address = r_addr;
    assign cap.write_sample  = r_sample;
    assign cap.read_index    = r_read_index;
endmodule
